control_unit: RTL and testbench

- Multi-cycle FSM sequencer that drives every load, increment and mux-select input of processing_unit.
- Consumes `instruction` and `Zflag` from the datapath.
- Produces the per-cycle control word for fetch, decode, execute, memory read/write and branch.
- Also produces the memory write strobe and halt/illegal status to the top level.

---
 rtl/control_unit_pkg.sv | 55 +++++
 rtl/control_unit_reg_load_decoder.sv | 16 +
 rtl/control_unit.sv | 176 +++++++++++++++++
 tb/tb_control_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// Shared definitions for the control_unit sequencer: widths, opcodes,
// FSM state encodings, bus mux select codes and instruction field positions.
package control_unit_pkg;

    localparam int word_size  = 16;
    localparam int op_size    = 5;
    localparam int sel1_size  = 4;
    localparam int sel2_size  = 2;
    localparam int state_size = 4;

    localparam int op_msb  = 15;
    localparam int op_lsb  = 11;
    localparam int src_msb = 10;
    localparam int src_lsb = 8;
    localparam int dst_msb = 7;
    localparam int dst_lsb = 5;

    localparam logic [op_size-1:0] OP_NOP  = 5'd0;
    localparam logic [op_size-1:0] OP_ADD  = 5'd1;
    localparam logic [op_size-1:0] OP_SUB  = 5'd2;
    localparam logic [op_size-1:0] OP_AND  = 5'd3;
    localparam logic [op_size-1:0] OP_NOT  = 5'd4;
    localparam logic [op_size-1:0] OP_RD   = 5'd5;
    localparam logic [op_size-1:0] OP_WR   = 5'd6;
    localparam logic [op_size-1:0] OP_BR   = 5'd7;
    localparam logic [op_size-1:0] OP_BRZ  = 5'd8;
    localparam logic [op_size-1:0] OP_HALT = 5'd9;

    // bus_1 codes 0-7 select R0-R7 directly; 9-15 are never driven.
    localparam logic [sel1_size-1:0] BUS1_PC = 4'd8;

    localparam logic [sel2_size-1:0] BUS2_ALU  = 2'd0;
    localparam logic [sel2_size-1:0] BUS2_BUS1 = 2'd1;
    localparam logic [sel2_size-1:0] BUS2_MEM  = 2'd2;

    typedef enum logic [state_size-1:0] {
        S_idle = 4'd0,
        S_fet1 = 4'd1,
        S_fet2 = 4'd2,
        S_dec  = 4'd3,
        S_ex1  = 4'd4,
        S_rd1  = 4'd5,
        S_rd2  = 4'd6,
        S_wr1  = 4'd7,
        S_wr2  = 4'd8,
        S_br1  = 4'd9,
        S_br2  = 4'd10,
        S_halt = 4'd11
    } state_t;

    function automatic logic [sel1_size-1:0] reg_sel(input logic [2:0] idx);
        return {1'b0, idx};
    endfunction

endpackage

// File: rtl/control_unit_reg_load_decoder.sv
// Register-file load decoder: one-hot 3-to-8 decode of a register index,
// gated by an enable so at most one load_Rn is ever high.
module control_unit_reg_load_decoder (
    input  logic       en,
    input  logic [2:0] idx,
    output logic [7:0] load
);

    always_comb begin
        load = '0;
        if (en) begin
            load[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle FSM sequencer producing the per-cycle control word for the
// processing_unit datapath, plus memory write strobe and halt/illegal status.
module control_unit
    import control_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [word_size-1:0]  instruction,
    input  logic                  Zflag,
    output logic                  load_R0,
    output logic                  load_R1,
    output logic                  load_R2,
    output logic                  load_R3,
    output logic                  load_R4,
    output logic                  load_R5,
    output logic                  load_R6,
    output logic                  load_R7,
    output logic                  load_PC,
    output logic                  inc_PC,
    output logic                  load_IR,
    output logic                  load_add_R,
    output logic                  load_reg_Y,
    output logic                  load_reg_Z,
    output logic [sel1_size-1:0]  sel_bus_1_MUX,
    output logic [sel2_size-1:0]  sel_bus_2_MUX,
    output logic                  write,
    output logic                  halted,
    output logic                  illegal_op,
    output logic [state_size-1:0] state_dbg
);

    state_t               state, next_state;
    logic [op_size-1:0]   opcode;
    logic [2:0]           src, dest;
    logic                 reg_load_en;
    logic                 set_illegal;
    logic [7:0]           reg_load;
    logic                 unused_bits;

    assign opcode      = instruction[op_msb:op_lsb];
    assign src         = instruction[src_msb:src_lsb];
    assign dest        = instruction[dst_msb:dst_lsb];
    assign unused_bits = ^instruction[dst_lsb-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_idle;
            illegal_op <= 1'b0;
        end else begin
            state <= next_state;
            if (set_illegal) begin
                illegal_op <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state    = state;
        load_PC       = 1'b0;
        inc_PC        = 1'b0;
        load_IR       = 1'b0;
        load_add_R    = 1'b0;
        load_reg_Y    = 1'b0;
        load_reg_Z    = 1'b0;
        sel_bus_1_MUX = '0;
        sel_bus_2_MUX = '0;
        write         = 1'b0;
        reg_load_en   = 1'b0;
        set_illegal   = 1'b0;
        case (state)
            S_idle: next_state = S_fet1;
            S_fet1: begin
                sel_bus_1_MUX = BUS1_PC;
                sel_bus_2_MUX = BUS2_BUS1;
                load_add_R    = 1'b1;
                next_state    = S_fet2;
            end
            S_fet2: begin
                sel_bus_2_MUX = BUS2_MEM;
                load_IR       = 1'b1;
                inc_PC        = 1'b1;
                next_state    = S_dec;
            end
            S_dec: begin
                case (opcode)
                    OP_NOP: next_state = S_fet1;
                    OP_ADD, OP_SUB, OP_AND: begin
                        sel_bus_1_MUX = reg_sel(src);
                        sel_bus_2_MUX = BUS2_BUS1;
                        load_reg_Y    = 1'b1;
                        next_state    = S_ex1;
                    end
                    OP_NOT: begin
                        sel_bus_1_MUX = reg_sel(src);
                        sel_bus_2_MUX = BUS2_ALU;
                        reg_load_en   = 1'b1;
                        load_reg_Z    = 1'b1;
                        next_state    = S_fet1;
                    end
                    OP_RD, OP_WR, OP_BR: begin
                        sel_bus_1_MUX = BUS1_PC;
                        sel_bus_2_MUX = BUS2_BUS1;
                        load_add_R    = 1'b1;
                        next_state    = (opcode == OP_RD) ? S_rd1 :
                                        (opcode == OP_WR) ? S_wr1 : S_br1;
                    end
                    OP_BRZ: begin
                        if (Zflag) begin
                            sel_bus_1_MUX = BUS1_PC;
                            sel_bus_2_MUX = BUS2_BUS1;
                            load_add_R    = 1'b1;
                            next_state    = S_br1;
                        end else begin
                            // Not taken: step PC past the branch target word.
                            inc_PC     = 1'b1;
                            next_state = S_fet1;
                        end
                    end
                    OP_HALT: next_state = S_halt;
                    default: begin
                        set_illegal = 1'b1;
                        next_state  = S_halt;
                    end
                endcase
            end
            S_ex1: begin
                sel_bus_1_MUX = reg_sel(dest);
                sel_bus_2_MUX = BUS2_ALU;
                reg_load_en   = 1'b1;
                load_reg_Z    = 1'b1;
                next_state    = S_fet1;
            end
            S_rd1, S_wr1: begin
                sel_bus_2_MUX = BUS2_MEM;
                load_add_R    = 1'b1;
                inc_PC        = 1'b1;
                next_state    = (state == S_rd1) ? S_rd2 : S_wr2;
            end
            S_rd2: begin
                sel_bus_2_MUX = BUS2_MEM;
                reg_load_en   = 1'b1;
                next_state    = S_fet1;
            end
            S_wr2: begin
                sel_bus_1_MUX = reg_sel(src);
                write         = 1'b1;
                next_state    = S_fet1;
            end
            S_br1: begin
                sel_bus_2_MUX = BUS2_MEM;
                load_add_R    = 1'b1;
                next_state    = S_br2;
            end
            S_br2: begin
                sel_bus_2_MUX = BUS2_MEM;
                load_PC       = 1'b1;
                next_state    = S_fet1;
            end
            S_halt: next_state = S_halt;
            default: next_state = S_idle;
        endcase
    end

    control_unit_reg_load_decoder u_reg_load_decoder (
        .en   (reg_load_en),
        .idx  (dest),
        .load (reg_load)
    );

    assign {load_R7, load_R6, load_R5, load_R4,
            load_R3, load_R2, load_R1, load_R0} = reg_load;

    assign halted    = (state == S_halt);
    assign state_dbg = state;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: expected control words are queued per
// cycle and compared against the DUT on the falling edge.
module tb_control_unit;
    import control_unit_pkg::*;

    localparam int W = 27;

    typedef struct packed {
        logic [3:0] st;
        logic [7:0] ld_r;
        logic       ld_pc;
        logic       inc_pc;
        logic       ld_ir;
        logic       ld_ar;
        logic       ld_y;
        logic       ld_z;
        logic [3:0] s1;
        logic [1:0] s2;
        logic       wr;
        logic       halt;
        logic       ill;
    } ctl_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instruction;
    logic        Zflag;
    logic        load_R0, load_R1, load_R2, load_R3, load_R4, load_R5, load_R6, load_R7;
    logic        load_PC, inc_PC, load_IR, load_add_R, load_reg_Y, load_reg_Z;
    logic [3:0]  sel_bus_1_MUX;
    logic [1:0]  sel_bus_2_MUX;
    logic        write, halted, illegal_op;
    logic [3:0]  state_dbg;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .rst(rst), .instruction(instruction), .Zflag(Zflag),
        .load_R0(load_R0), .load_R1(load_R1), .load_R2(load_R2), .load_R3(load_R3),
        .load_R4(load_R4), .load_R5(load_R5), .load_R6(load_R6), .load_R7(load_R7),
        .load_PC(load_PC), .inc_PC(inc_PC), .load_IR(load_IR), .load_add_R(load_add_R),
        .load_reg_Y(load_reg_Y), .load_reg_Z(load_reg_Z),
        .sel_bus_1_MUX(sel_bus_1_MUX), .sel_bus_2_MUX(sel_bus_2_MUX),
        .write(write), .halted(halted), .illegal_op(illegal_op), .state_dbg(state_dbg)
    );

    function automatic logic [15:0] mk(input logic [4:0] op, input logic [2:0] src,
                                       input logic [2:0] dst);
        return {op, src, dst, 5'b0};
    endfunction

    function automatic ctl_t observe();
        ctl_t c;
        c.st     = state_dbg;
        c.ld_r   = {load_R7, load_R6, load_R5, load_R4, load_R3, load_R2, load_R1, load_R0};
        c.ld_pc  = load_PC;
        c.inc_pc = inc_PC;
        c.ld_ir  = load_IR;
        c.ld_ar  = load_add_R;
        c.ld_y   = load_reg_Y;
        c.ld_z   = load_reg_Z;
        c.s1     = sel_bus_1_MUX;
        c.s2     = sel_bus_2_MUX;
        c.wr     = write;
        c.halt   = halted;
        c.ill    = illegal_op;
        return c;
    endfunction

    function automatic ctl_t blank(input logic [3:0] st);
        ctl_t c;
        c    = '0;
        c.st = st;
        return c;
    endfunction

    task automatic push(input ctl_t c, input string tag);
        exp_q.push_back(c);
        tag_q.push_back(tag);
    endtask

    task automatic push_fetch(input string n);
        ctl_t c;
        c = blank(4'd1); c.s1 = 4'd8; c.s2 = 2'd1; c.ld_ar = 1'b1;
        push(c, {n, "_fet1"});
        c = blank(4'd2); c.s2 = 2'd2; c.ld_ir = 1'b1; c.inc_pc = 1'b1;
        push(c, {n, "_fet2"});
    endtask

    // Decode step shared by RD/WR/BR/BRZ-taken: latch operand address from PC.
    task automatic push_dec_addr(input string n);
        ctl_t c;
        c = blank(4'd3); c.s1 = 4'd8; c.s2 = 2'd1; c.ld_ar = 1'b1;
        push(c, {n, "_dec"});
    endtask

    task automatic check_now();
        ctl_t  e, o;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = observe();
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", t, o, e);
        end
    endtask

    task automatic drain();
        while (exp_q.size() > 0) begin
            check_now();
            @(negedge clk);
        end
    endtask

    initial begin
        ctl_t c;
        instruction = mk(5'd0, 3'd0, 3'd0);
        Zflag       = 1'b0;
        rst         = 1'b1;

        @(negedge clk);
        push(blank(4'd0), "reset_hold");
        check_now();

        // NOP
        rst = 1'b0;
        push(blank(4'd0), "idle");
        push_fetch("nop");
        push(blank(4'd3), "nop_dec");
        drain();

        // ADD src=2 dest=3
        instruction = mk(5'd1, 3'd2, 3'd3);
        push_fetch("add");
        c = blank(4'd3); c.s1 = 4'd2; c.s2 = 2'd1; c.ld_y = 1'b1; push(c, "add_dec");
        c = blank(4'd4); c.s1 = 4'd3; c.s2 = 2'd0; c.ld_r = 8'b0000_1000; c.ld_z = 1'b1;
        push(c, "add_ex1");
        drain();

        // WR src=5
        instruction = mk(5'd6, 3'd5, 3'd0);
        push_fetch("wr");
        push_dec_addr("wr");
        c = blank(4'd7); c.s2 = 2'd2; c.ld_ar = 1'b1; c.inc_pc = 1'b1; push(c, "wr_wr1");
        c = blank(4'd8); c.s1 = 4'd5; c.wr = 1'b1; push(c, "wr_wr2");
        drain();

        // NOT src=1 dest=6
        instruction = mk(5'd4, 3'd1, 3'd6);
        push_fetch("not");
        c = blank(4'd3); c.s1 = 4'd1; c.s2 = 2'd0; c.ld_r = 8'b0100_0000; c.ld_z = 1'b1;
        push(c, "not_dec");
        drain();

        // RD dest=4
        instruction = mk(5'd5, 3'd0, 3'd4);
        push_fetch("rd");
        push_dec_addr("rd");
        c = blank(4'd5); c.s2 = 2'd2; c.ld_ar = 1'b1; c.inc_pc = 1'b1; push(c, "rd_rd1");
        c = blank(4'd6); c.s2 = 2'd2; c.ld_r = 8'b0001_0000; push(c, "rd_rd2");
        drain();

        // BRZ not taken
        instruction = mk(5'd8, 3'd0, 3'd0);
        Zflag = 1'b0;
        push_fetch("brz0");
        c = blank(4'd3); c.inc_pc = 1'b1; push(c, "brz0_dec");
        drain();

        // BRZ taken
        Zflag = 1'b1;
        push_fetch("brz1");
        push_dec_addr("brz1");
        c = blank(4'd9); c.s2 = 2'd2; c.ld_ar = 1'b1; push(c, "brz1_br1");
        c = blank(4'd10); c.s2 = 2'd2; c.ld_pc = 1'b1; push(c, "brz1_br2");
        drain();
        Zflag = 1'b0;

        // BR unconditional
        instruction = mk(5'd7, 3'd0, 3'd0);
        push_fetch("br");
        push_dec_addr("br");
        c = blank(4'd9); c.s2 = 2'd2; c.ld_ar = 1'b1; push(c, "br_br1");
        c = blank(4'd10); c.s2 = 2'd2; c.ld_pc = 1'b1; push(c, "br_br2");
        drain();

        // WR interrupted by reset while in S_wr2
        instruction = mk(5'd6, 3'd3, 3'd0);
        push_fetch("wrx");
        push_dec_addr("wrx");
        c = blank(4'd7); c.s2 = 2'd2; c.ld_ar = 1'b1; c.inc_pc = 1'b1; push(c, "wrx_wr1");
        drain();
        c = blank(4'd8); c.s1 = 4'd3; c.wr = 1'b1; push(c, "wrx_wr2");
        check_now();
        #2 rst = 1'b1;
        #1 push(blank(4'd0), "wrx_async_rst");
        check_now();
        @(negedge clk);
        push(blank(4'd0), "wrx_rst_hold");
        check_now();
        rst = 1'b0;
        instruction = mk(5'd0, 3'd0, 3'd0);
        push(blank(4'd0), "restart_idle");
        push_fetch("restart");
        push(blank(4'd3), "restart_dec");
        drain();

        // HALT
        instruction = mk(5'd9, 3'd0, 3'd0);
        push_fetch("halt");
        push(blank(4'd3), "halt_dec");
        c = blank(4'd11); c.halt = 1'b1;
        push(c, "halt_st");
        push(c, "halt_stay");
        drain();

        // Illegal opcode 5'b11111, then async clear
        rst = 1'b1;
        #1 push(blank(4'd0), "halt_rst");
        check_now();
        @(negedge clk);
        rst = 1'b0;
        instruction = mk(5'h1f, 3'd0, 3'd0);
        push(blank(4'd0), "ill_idle");
        push_fetch("ill");
        push(blank(4'd3), "ill_dec");
        c = blank(4'd11); c.halt = 1'b1; c.ill = 1'b1;
        push(c, "ill_halt");
        push(c, "ill_stay");
        drain();
        #2 rst = 1'b1;
        #1 push(blank(4'd0), "ill_async_clr");
        check_now();

        // Lowest illegal opcode
        @(negedge clk);
        rst = 1'b0;
        instruction = mk(5'd10, 3'd0, 3'd0);
        push(blank(4'd0), "ill10_idle");
        push_fetch("ill10");
        push(blank(4'd3), "ill10_dec");
        c = blank(4'd11); c.halt = 1'b1; c.ill = 1'b1;
        push(c, "ill10_halt");
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
